code_sequence_checker: RTL and testbench

- Keypad-side verification stage for the anti-impersonation lock. Accepts 4-bit digits one at a time.
- Drives the address of the stored-code ROM, which has 1-cycle registered read. Consumes the ROM data word and compares it with each entered digit.
- After CODE_LEN digits, issues a grant or deny pulse. Enforces a lockout after repeated failures.

---
 rtl/code_sequence_checker.sv | 129 ++++++++++++
 tb/tb_code_sequence_checker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_sequence_checker.sv
// Keypad code checker: reads stored digits from a 1-cycle ROM, grants or denies after CODE_LEN digits, locks out after MAX_FAILS denials.
// Verdict pulse 3 cycles after the last accepted key; keys are accepted only when busy is low and are dropped otherwise.
module code_sequence_checker #(
  parameter int CODE_LEN    = 5,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter int TIMEOUT     = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              access_ok,
  output logic              access_denied,
  output logic              locked,
  output logic [1:0]        fail_count
);

  localparam int TMAX = (LOCK_CYCLES > TIMEOUT) ? LOCK_CYCLES : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_READ, S_CMP, S_RESULT, S_GRANT, S_DENY, S_LOCK
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              mismatch_q, mismatch_d;
  logic [1:0]        fail_q, fail_d;
  logic [TW-1:0]     timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      key_q      <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      key_q      <= key_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    key_d         = key_q;
    mismatch_d    = mismatch_q;
    fail_d        = fail_q;
    timer_d       = timer_q;
    busy          = 1'b1;
    access_ok     = 1'b0;
    access_denied = 1'b0;
    locked        = 1'b0;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        busy = 1'b0;
        // A key on the expiry cycle wins over the timeout.
        if (key_valid) begin
          key_d   = key_data;
          timer_d = '0;
          state_d = S_READ;
        end else if (state_q == S_COLLECT) begin
          if (timer_q == TW'(TIMEOUT - 1)) begin
            timer_d = '0;
            state_d = S_DENY;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_READ: state_d = S_CMP;
      S_CMP: begin
        if (rom_data != key_q) mismatch_d = 1'b1;
        if (idx_q == ADDR_W'(CODE_LEN - 1)) begin
          state_d = S_RESULT;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          timer_d = '0;
          state_d = S_COLLECT;
        end
      end
      S_RESULT: state_d = mismatch_q ? S_DENY : S_GRANT;
      S_GRANT: begin
        access_ok  = 1'b1;
        fail_d     = '0;
        idx_d      = '0;
        mismatch_d = 1'b0;
        state_d    = S_IDLE;
      end
      S_DENY: begin
        access_denied = 1'b1;
        fail_d        = (fail_q == 2'(MAX_FAILS)) ? fail_q : fail_q + 2'd1;
        idx_d         = '0;
        mismatch_d    = 1'b0;
        timer_d       = '0;
        state_d       = (fail_d == 2'(MAX_FAILS)) ? S_LOCK : S_IDLE;
      end
      S_LOCK: begin
        locked = 1'b1;
        if (timer_q == TW'(LOCK_CYCLES - 1)) begin
          timer_d = '0;
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_addr   = idx_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_code_sequence_checker.sv
// Bench for code_sequence_checker: per-cycle outputs compared against a timeline model built from the key schedule.
module tb_code_sequence_checker;

  localparam int CL = 5, MF = 3, LC = 20, TO = 10, NMAX = 400;

  logic       clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0;
  logic [3:0] key_data = '0, rom_addr, rom_data = '0;
  logic       busy, access_ok, access_denied, locked;
  logic [1:0] fail_count;

  always #5 clk = ~clk;

  code_sequence_checker #(
    .CODE_LEN(CL), .ADDR_W(4), .DATA_W(4), .MAX_FAILS(MF), .LOCK_CYCLES(LC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_data(key_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .access_ok(access_ok),
    .access_denied(access_denied), .locked(locked), .fail_count(fail_count)
  );

  // Code ROM 0..4; unused entries hold F so stray addressing shows up.
  logic [3:0] rom_mem [16];
  initial for (int i = 0; i < 16; i++) rom_mem[i] = (i < CL) ? 4'(i) : 4'hF;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int nerr = 0, nchk = 0;
  logic       kv [NMAX];
  logic [3:0] kd [NMAX];
  logic [9:0] obs [NMAX], exp_v [NMAX];

  // Timeline model state
  int m_ready, m_cnt, m_deadline, m_fails;
  logic m_mism;
  logic m_ok [NMAX], m_den [NMAX], m_lk [NMAX], m_bz [NMAX];
  logic [1:0] m_fc [NMAX];
  logic [3:0] m_ad [NMAX];

  function automatic logic [9:0] outs();
    return {access_ok, access_denied, locked, busy, fail_count, rom_addr};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < NMAX; i++) begin kv[i] = 1'b0; kd[i] = '0; end
  endtask

  task automatic put_key(input int k, input int d);
    kv[k] = 1'b1; kd[k] = 4'(d);
  endtask

  // digs holds digit i in nibble i
  task automatic put_seq(input int start, input int gap, input logic [19:0] digs);
    for (int i = 0; i < CL; i++) put_key(start + i * gap, int'(digs[4*i +: 4]));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; key_valid = 1'b0; key_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      obs[k] = outs();
      key_valid = kv[k]; key_data = kd[k];
      @(negedge clk);
    end
    key_valid = 1'b0;
  endtask

  task automatic model_deny(input int p);
    m_den[p] = 1'b1; m_bz[p] = 1'b1;
    m_fails = (m_fails < MF) ? m_fails + 1 : MF;
    for (int j = p + 1; j < NMAX; j++) begin m_fc[j] = 2'(m_fails); m_ad[j] = '0; end
    m_cnt = 0; m_mism = 1'b0;
    if (m_fails == MF) begin
      for (int j = p + 1; j <= p + LC && j < NMAX; j++) begin m_lk[j] = 1'b1; m_bz[j] = 1'b1; end
      for (int j = p + LC + 1; j < NMAX; j++) m_fc[j] = 2'd0;
      m_fails = 0;
      m_ready = p + LC + 1;
    end else begin
      m_ready = p + 1;
    end
  endtask

  task automatic model_accept(input int k);
    if (kd[k] != 4'(m_cnt)) m_mism = 1'b1;
    m_bz[k+1] = 1'b1; m_bz[k+2] = 1'b1;
    m_cnt++;
    if (m_cnt < CL) begin
      m_ready = k + 3;
      m_deadline = k + 3 + TO - 1;
      for (int j = k + 3; j < NMAX; j++) m_ad[j] = 4'(m_cnt);
    end else begin
      m_bz[k+3] = 1'b1;
      if (!m_mism) begin
        m_ok[k+4] = 1'b1; m_bz[k+4] = 1'b1;
        m_fails = 0;
        for (int j = k + 5; j < NMAX; j++) begin m_fc[j] = 2'd0; m_ad[j] = '0; end
        m_cnt = 0;
        m_ready = k + 5;
      end else begin
        model_deny(k + 4);
      end
    end
  endtask

  task automatic build_model(input int n);
    m_ready = 0; m_cnt = 0; m_deadline = 0; m_fails = 0; m_mism = 1'b0;
    for (int j = 0; j < NMAX; j++) begin
      m_ok[j] = 0; m_den[j] = 0; m_lk[j] = 0; m_bz[j] = 0; m_fc[j] = '0; m_ad[j] = '0;
    end
    for (int k = 0; k < n; k++) begin
      if (m_cnt > 0 && k >= m_ready && k == m_deadline + 1) model_deny(k);
      if (kv[k] && k >= m_ready) model_accept(k);
    end
    for (int k = 0; k < n; k++) exp_v[k] = {m_ok[k], m_den[k], m_lk[k], m_bz[k], m_fc[k], m_ad[k]};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nchk++;
    if (outs() !== 10'd0) begin
      nerr++; $display("FAIL reset_hold got ok/den/lk/bz/fc/addr=%b want %b", outs(), 10'd0);
    end
    rst_n = 1'b1;
    #1;
    nchk++;
    if (outs() !== 10'd0) begin
      nerr++; $display("FAIL reset_release got %b want %b", outs(), 10'd0);
    end
    @(negedge clk);
  endtask

  task automatic test_grant();
    apply_reset(); clear_stim();
    put_seq(0, 4, 20'h43210);
    build_model(30); run(30);
    for (int k = 0; k < 30; k++) begin
      nchk++;
      if (obs[k] !== exp_v[k]) begin nerr++; $display("FAIL grant cyc=%0d got %b want %b", k, obs[k], exp_v[k]); end
    end
    nchk++;
    if (obs[20][9] !== 1'b1 || obs[19][9] !== 1'b0 || obs[21][9] !== 1'b0) begin
      nerr++; $display("FAIL grant_pulse got ok@19..21=%b%b%b want 010", obs[19][9], obs[20][9], obs[21][9]);
    end
  endtask

  task automatic test_mismatch();
    apply_reset(); clear_stim();
    put_seq(0, 4, 20'h43910);
    build_model(30); run(30);
    for (int k = 0; k < 30; k++) begin
      nchk++;
      if (obs[k] !== exp_v[k]) begin nerr++; $display("FAIL mismatch cyc=%0d got %b want %b", k, obs[k], exp_v[k]); end
    end
    nchk++;
    if (obs[20][8] !== 1'b1 || obs[21][5:4] !== 2'd1 || obs[16][3:0] !== 4'd4) begin
      nerr++; $display("FAIL deny_pulse got den=%b fc=%0d addr=%0d want 1 1 4", obs[20][8], obs[21][5:4], obs[16][3:0]);
    end
  endtask

  task automatic test_lockout();
    apply_reset(); clear_stim();
    put_seq(0, 4, 20'h43915);
    put_seq(24, 4, 20'h00000);
    put_seq(48, 4, 20'h53210);
    put_seq(70, 3, 20'h43210);
    put_seq(95, 4, 20'h43210);
    build_model(130); run(130);
    for (int k = 0; k < 130; k++) begin
      nchk++;
      if (obs[k] !== exp_v[k]) begin nerr++; $display("FAIL lockout cyc=%0d got %b want %b", k, obs[k], exp_v[k]); end
    end
    nchk++;
    if (obs[69][7] !== 1'b1 || obs[69][5:4] !== 2'd3 || obs[89][7] !== 1'b0 || obs[89][5:4] !== 2'd0) begin
      nerr++; $display("FAIL lock_window got lk69=%b fc69=%0d lk89=%b fc89=%0d want 1 3 0 0",
                       obs[69][7], obs[69][5:4], obs[89][7], obs[89][5:4]);
    end
  endtask

  task automatic test_timeout();
    apply_reset(); clear_stim();
    put_key(0, 0); put_key(4, 1);
    build_model(25); run(25);
    for (int k = 0; k < 25; k++) begin
      nchk++;
      if (obs[k] !== exp_v[k]) begin nerr++; $display("FAIL timeout cyc=%0d got %b want %b", k, obs[k], exp_v[k]); end
    end
    nchk++;
    if (obs[17][8] !== 1'b1 || obs[16][8] !== 1'b0 || obs[18][5:4] !== 2'd1 || obs[18][3:0] !== 4'd0) begin
      nerr++; $display("FAIL timeout_deny got den16=%b den17=%b fc=%0d addr=%0d want 0 1 1 0",
                       obs[16][8], obs[17][8], obs[18][5:4], obs[18][3:0]);
    end
    apply_reset(); clear_stim();
    put_key(0, 0); put_key(4, 1); put_key(16, 2); put_key(20, 3); put_key(24, 4);
    build_model(35); run(35);
    for (int k = 0; k < 35; k++) begin
      nchk++;
      if (obs[k] !== exp_v[k]) begin nerr++; $display("FAIL expiry_key cyc=%0d got %b want %b", k, obs[k], exp_v[k]); end
    end
    nchk++;
    if (obs[17][8] !== 1'b0 || obs[28][9] !== 1'b1) begin
      nerr++; $display("FAIL expiry_accept got den17=%b ok28=%b want 0 1", obs[17][8], obs[28][9]);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(); clear_stim();
    for (int k = 0; k < 70; k++) put_key(k, (k < 40) ? (k / 3) % 5 : k % 16);
    build_model(90); run(90);
    for (int k = 0; k < 90; k++) begin
      nchk++;
      if (obs[k] !== exp_v[k]) begin nerr++; $display("FAIL back_to_back cyc=%0d got %b want %b", k, obs[k], exp_v[k]); end
    end
    nchk++;
    if (obs[16][9] !== 1'b1 || obs[1][3:0] !== 4'd0 || obs[3][3:0] !== 4'd1) begin
      nerr++; $display("FAIL b2b_spacing got ok16=%b addr1=%0d addr3=%0d want 1 0 1", obs[16][9], obs[1][3:0], obs[3][3:0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int k, pos, gap, d;
      apply_reset(); clear_stim();
      k = 2; pos = 0;
      while (k < 280) begin
        d = ($urandom % 10 == 0) ? int'($urandom_range(0, 15)) : pos % CL;
        put_key(k, d);
        pos++;
        gap = ($urandom % 6 == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 14));
        k += gap;
      end
      build_model(300); run(300);
      for (int c = 0; c < 300; c++) begin
        nchk++;
        if (obs[c] !== exp_v[c]) begin nerr++; $display("FAIL random it=%0d cyc=%0d got %b want %b", it, c, obs[c], exp_v[c]); end
      end
    end
  endtask

  task automatic test_reset_midway();
    apply_reset(); clear_stim();
    put_key(0, 0); put_key(3, 1); put_key(6, 2);
    run(8);
    nchk++;
    if (outs() !== {4'b0001, 2'd0, 4'd2}) begin
      nerr++; $display("FAIL pre_reset_cmp got %b want %b", outs(), {4'b0001, 2'd0, 4'd2});
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (outs() !== 10'd0) begin nerr++; $display("FAIL async_reset_cmp got %b want %b", outs(), 10'd0); end
    @(negedge clk); rst_n = 1'b1;
    clear_stim(); put_seq(0, 4, 20'h43210);
    build_model(25); run(25);
    for (int k = 0; k < 25; k++) begin
      nchk++;
      if (obs[k] !== exp_v[k]) begin nerr++; $display("FAIL after_reset_cmp cyc=%0d got %b want %b", k, obs[k], exp_v[k]); end
    end
    apply_reset(); clear_stim();
    put_seq(0, 4, 20'h43910); put_seq(24, 4, 20'h43910); put_seq(48, 4, 20'h43910);
    run(75);
    nchk++;
    if (outs() !== {4'b0011, 2'd3, 4'd0}) begin
      nerr++; $display("FAIL pre_reset_lock got %b want %b", outs(), {4'b0011, 2'd3, 4'd0});
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if (outs() !== 10'd0) begin nerr++; $display("FAIL async_reset_lock got %b want %b", outs(), 10'd0); end
    @(negedge clk); rst_n = 1'b1;
    clear_stim(); put_seq(0, 4, 20'h43210);
    build_model(25); run(25);
    for (int k = 0; k < 25; k++) begin
      nchk++;
      if (obs[k] !== exp_v[k]) begin nerr++; $display("FAIL after_reset_lock cyc=%0d got %b want %b", k, obs[k], exp_v[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_mismatch();
    test_lockout();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
